vid_mux_sched: RTL and testbench
================================

VID_MUX_SCHED -- requirements
Module: vid_mux_sched

Interface
REQ-001 Parameter NIN, 5, number of video sources feeding the downstream video mux.
REQ-002 Parameter LGNIN, $clog2(NIN), width of every select field.
REQ-003 Parameter LGTIMEOUT, 20, width of each per-source liveness watchdog.
REQ-004 Parameter TIMEOUT, 2**LGTIMEOUT-1, cycles without VALID before a source is declared dead.
REQ-005 Parameter LGDWELL, 8, width of the frame-dwell count.
REQ-006 Parameter DEF_SELECT, 0, select after reset; 0 is used if DEF_SELECT >= NIN.
REQ-007 S_AXI_ACLK  in  1  sole clock; one clock; reset is asynchronous and active-high.
REQ-008 S_AXI_ARESET  in  1  asynchronous, active-high reset.
REQ-009 i_src_valid  in  NIN  raw per-source stream VALID; activity indication only.
REQ-010 i_out_eof  in  1  one-cycle pulse: mux output accepted the last beat of a frame.
REQ-011 i_mode  in  2  0 manual, 1 failover, 2 round-robin cycle, 3 treated as manual.
REQ-012 i_manual_sel  in  LGNIN  manual select, also the preferred source in failover.
REQ-013 i_dwell  in  LGDWELL  frames per source in cycle mode; 0 is treated as 1.
REQ-014 o_select  out  LGNIN  registered select, driven to the mux select input.
REQ-015 o_live  out  NIN  per-source liveness flags.
REQ-016 o_none_live  out  1  high when o_live is all zero.
REQ-017 o_switch  out  1  one-cycle pulse, coincident with each change of o_select.

Function
REQ-018 Watchdog per source: load TIMEOUT when i_src_valid[k] is high, else decrement, saturating at 0.
REQ-019 o_live[k] SHALL be (watchdog[k] != 0), registered.
REQ-020 Decision point: any cycle with i_out_eof high, or with o_live[o_select] low.
REQ-021 The FSM SHALL have exactly three states: WAIT_LIVE, RUN and SWITCH.
REQ-022 WAIT_LIVE (entered when o_none_live): hold o_select; on any o_live bit rising, compute the target and go to SWITCH.
REQ-023 RUN: at a decision point, compute the target; if it differs from o_select, go to SWITCH, else stay in RUN.
REQ-024 SWITCH (one cycle): o_select = target, o_switch = 1, frame counter cleared, next state RUN.
REQ-025 Manual target: i_manual_sel if < NIN, else the current o_select; liveness ignored.
REQ-026 Failover target: i_manual_sel if < NIN and live, else the lowest-index live source, else hold.
REQ-027 Cycle mode: the frame counter increments on i_out_eof.
REQ-028 Cycle target: on reaching max(i_dwell,1), or on death of the selected source, the first live index scanning upward from o_select+1 with wrap; hold if none.
REQ-029 Latency: o_select SHALL change exactly 2 cycles after the decision-point cycle (decision cycle, then SWITCH, then the registered output).
REQ-030 Simultaneous i_out_eof and death of the selected source SHALL be handled once, as a death.
REQ-031 A change of i_mode SHALL clear the frame counter and take effect at the next decision point only.
REQ-032 i_src_valid and a zero watchdog in the same cycle: the reload wins and the source stays live.
REQ-033 Frame-boundary alignment SHALL NOT be performed here; the mux performs it, so o_select may change mid-frame.

Reset
REQ-034 Asserting S_AXI_ARESET at any time, including during SWITCH, SHALL immediately set:
- o_select = DEF_SELECT (or 0 per REQ-006);
- o_live = 0, o_none_live = 1, o_switch = 0;
- all watchdogs 0, frame counter 0, state WAIT_LIVE.

Structure
REQ-035 Mode encodings and FSM state encodings SHALL live in a shared package, vid_pkg.
REQ-036 The wrap-around next-live search SHALL be one combinational sub-module, vid_sched_rrpick (inputs: NIN-bit mask, start index; outputs: index, found).

Verification (NIN=4, TIMEOUT=16)
REQ-037 Reset with DEF_SELECT=2 -> o_select=2, o_live=0000, o_none_live=1, o_switch=0.
REQ-038 Failover, i_manual_sel=0, sources 0 and 2 active; stop source 0 -> live[0] low 16 cycles later, o_select=2 two cycles after that, single o_switch pulse.
REQ-039 Cycle, i_dwell=2, sources 0-2 active, source 3 idle -> o_select 0->1 after the 2nd eof, 1->2 after the 4th, 2->0 after the 6th (3 skipped).
REQ-040 Manual, i_manual_sel=5 (LGNIN=2 truncates to 1; use NIN=5 with i_manual_sel=6) -> o_select unchanged, no o_switch pulse.
REQ-041 All sources idle -> WAIT_LIVE, o_select held; source 3 resumes in failover -> o_select=3, one o_switch pulse.
REQ-042 S_AXI_ARESET asserted during SWITCH -> outputs take REQ-034 values in the same cycle; no o_switch pulse.

Source files
------------

// File: rtl/vid_pkg.sv
// Shared encodings for the video-source scheduler: operating modes and FSM states.
package vid_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL     = 2'd0,
        MODE_FAILOVER   = 2'd1,
        MODE_CYCLE      = 2'd2,
        MODE_MANUAL_ALT = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        WAIT_LIVE = 2'd0,
        RUN       = 2'd1,
        SWITCH    = 2'd2
    } sched_state_e;

endpackage

// File: rtl/vid_sched_rrpick.sv
// Wrap-around search: first set bit of mask at or above start, wrapping past NIN-1 to 0.
module vid_sched_rrpick #(
    parameter int NIN   = 5,
    parameter int LGNIN = $clog2(NIN)
) (
    input  logic [NIN-1:0]   mask,
    input  logic [LGNIN-1:0] start,
    output logic [LGNIN-1:0] idx,
    output logic             found
);

    localparam logic [LGNIN:0] NIN_W = (LGNIN+1)'(NIN);

    logic [2*NIN-1:0] dbl;
    logic [NIN-1:0]   rot;
    logic [LGNIN-1:0] off;
    logic [LGNIN:0]   sum;

    // Doubling the mask turns the wrap into a plain shift.
    assign dbl = {mask, mask};
    assign rot = NIN'(dbl >> start);

    always_comb begin
        off   = '0;
        found = 1'b0;
        for (int i = NIN - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off   = LGNIN'(i);
                found = 1'b1;
            end
        end
    end

    assign sum = {1'b0, start} + {1'b0, off};
    assign idx = (sum >= NIN_W) ? LGNIN'(sum - NIN_W) : sum[LGNIN-1:0];

endmodule

// File: rtl/vid_mux_sched.sv
// Video mux source scheduler: per-source liveness watchdogs plus a select FSM
// implementing manual, failover and round-robin frame-dwell policies.
//
// state     | meaning
// WAIT_LIVE | no source live; select held until any source comes alive
// RUN       | select stable; re-evaluated on end-of-frame or death of selected source
// SWITCH    | one cycle; registered target is driven onto o_select with o_switch
module vid_mux_sched
    import vid_pkg::*;
#(
    parameter int NIN        = 5,
    parameter int LGNIN      = $clog2(NIN),
    parameter int LGTIMEOUT  = 20,
    parameter int TIMEOUT    = 2**LGTIMEOUT - 1,
    parameter int LGDWELL    = 8,
    parameter int DEF_SELECT = 0
) (
    input  logic               S_AXI_ACLK,
    input  logic               S_AXI_ARESET,
    input  logic [NIN-1:0]     i_src_valid,
    input  logic               i_out_eof,
    input  logic [1:0]         i_mode,
    input  logic [LGNIN-1:0]   i_manual_sel,
    input  logic [LGDWELL-1:0] i_dwell,
    output logic [LGNIN-1:0]   o_select,
    output logic [NIN-1:0]     o_live,
    output logic               o_none_live,
    output logic               o_switch
);

    localparam int SEL_DEF = (DEF_SELECT >= NIN || DEF_SELECT < 0) ? 0 : DEF_SELECT;
    localparam logic [LGNIN-1:0]     SEL_RST  = LGNIN'(SEL_DEF);
    localparam logic [LGNIN-1:0]     SEL_LAST = LGNIN'(NIN - 1);
    localparam logic [LGNIN-1:0]     SEL_ONE  = LGNIN'(1);
    localparam logic [LGNIN:0]       NIN_W    = (LGNIN+1)'(NIN);
    localparam logic [LGTIMEOUT-1:0] WD_LOAD  = LGTIMEOUT'(TIMEOUT);
    localparam logic [LGTIMEOUT-1:0] WD_ONE   = LGTIMEOUT'(1);
    localparam logic [LGDWELL-1:0]   DW_ONE   = LGDWELL'(1);
    localparam logic [LGDWELL:0]     CNT_ONE  = (LGDWELL+1)'(1);

    logic [LGTIMEOUT-1:0] wdog     [NIN];
    logic [LGTIMEOUT-1:0] wdog_nxt [NIN];

    sched_state_e       state, state_nxt;
    logic [LGNIN-1:0]   target, target_q, target_nxt, sel_nxt;
    logic               switch_nxt;
    logic [LGDWELL-1:0] frame_cnt, cnt_nxt, cnt_base, dwell_eff;
    logic [LGDWELL:0]   cnt_inc;
    logic               dwell_hit;
    logic [1:0]         mode_q;
    mode_e              mode;
    logic               mode_chg, sel_live, msel_ok, rescan;

    logic [LGNIN-1:0]   nxt_start, next_idx, low_idx;
    logic               next_found, low_found;

    // Reload wins over expiry, so a VALID on the last live cycle keeps the source live.
    always_comb begin
        for (int k = 0; k < NIN; k++) begin
            if (i_src_valid[k])
                wdog_nxt[k] = WD_LOAD;
            else if (wdog[k] != '0)
                wdog_nxt[k] = wdog[k] - WD_ONE;
            else
                wdog_nxt[k] = '0;
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int k = 0; k < NIN; k++)
                wdog[k] <= '0;
            o_live <= '0;
        end else begin
            for (int k = 0; k < NIN; k++) begin
                wdog[k]   <= wdog_nxt[k];
                o_live[k] <= (wdog_nxt[k] != '0);
            end
        end
    end

    assign o_none_live = ~|o_live;

    assign nxt_start = (o_select == SEL_LAST) ? '0 : o_select + SEL_ONE;

    vid_sched_rrpick #(.NIN(NIN), .LGNIN(LGNIN)) u_pick_next (
        .mask  (o_live),
        .start (nxt_start),
        .idx   (next_idx),
        .found (next_found)
    );

    vid_sched_rrpick #(.NIN(NIN), .LGNIN(LGNIN)) u_pick_low (
        .mask  (o_live),
        .start ('0),
        .idx   (low_idx),
        .found (low_found)
    );

    assign mode      = mode_e'(i_mode);
    assign mode_chg  = (i_mode != mode_q);
    assign sel_live  = o_live[o_select];
    assign msel_ok   = ({1'b0, i_manual_sel} < NIN_W);
    assign rescan    = (state == WAIT_LIVE) || !sel_live;
    assign cnt_base  = mode_chg ? '0 : frame_cnt;
    assign cnt_inc   = {1'b0, cnt_base} + CNT_ONE;
    assign dwell_eff = (i_dwell == '0) ? DW_ONE : i_dwell;
    assign dwell_hit = (cnt_inc >= {1'b0, dwell_eff});

    always_comb begin
        target = o_select;
        case (mode)
            MODE_FAILOVER: begin
                if (msel_ok && o_live[i_manual_sel])
                    target = i_manual_sel;
                else if (low_found)
                    target = low_idx;
            end
            MODE_CYCLE: begin
                // A dead selection rescans immediately; the frame count only matters while it lives.
                if ((rescan || (i_out_eof && dwell_hit)) && next_found)
                    target = next_idx;
            end
            default: begin
                if (msel_ok)
                    target = i_manual_sel;
            end
        endcase
    end

    always_comb begin
        state_nxt  = state;
        target_nxt = target_q;
        sel_nxt    = o_select;
        switch_nxt = 1'b0;
        cnt_nxt    = cnt_base;
        case (state)
            WAIT_LIVE: begin
                if (!o_none_live) begin
                    if (target != o_select) begin
                        state_nxt  = SWITCH;
                        target_nxt = target;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (o_none_live) begin
                    state_nxt = WAIT_LIVE;
                end else begin
                    if (mode == MODE_CYCLE && i_out_eof && sel_live)
                        cnt_nxt = dwell_hit ? '0 : cnt_inc[LGDWELL-1:0];
                    if ((i_out_eof || !sel_live) && target != o_select) begin
                        state_nxt  = SWITCH;
                        target_nxt = target;
                    end
                end
            end
            SWITCH: begin
                sel_nxt    = target_q;
                switch_nxt = 1'b1;
                cnt_nxt    = '0;
                state_nxt  = RUN;
            end
            default: state_nxt = WAIT_LIVE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state     <= WAIT_LIVE;
            target_q  <= SEL_RST;
            o_select  <= SEL_RST;
            o_switch  <= 1'b0;
            frame_cnt <= '0;
            mode_q    <= MODE_MANUAL;
        end else begin
            state     <= state_nxt;
            target_q  <= target_nxt;
            o_select  <= sel_nxt;
            o_switch  <= switch_nxt;
            frame_cnt <= cnt_nxt;
            mode_q    <= i_mode;
        end
    end

endmodule

// File: tb/tb_vid_mux_sched.sv
// Bench for vid_mux_sched: per-cycle reference model plus directed scenarios with literal expectations.
module tb_vid_mux_sched;

    localparam int NIN        = 5;
    localparam int LGNIN      = 3;
    localparam int LGTIMEOUT  = 5;
    localparam int TIMEOUT    = 16;
    localparam int LGDWELL    = 8;
    localparam int DEF_SELECT = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NIN-1:0]     valid = '0;
    logic               eof = 1'b0;
    logic [1:0]         mode = 2'd0;
    logic [LGNIN-1:0]   msel = 3'd2;
    logic [LGDWELL-1:0] dwell = 8'd1;

    logic [LGNIN-1:0]   o_select;
    logic [NIN-1:0]     o_live;
    logic               o_none_live;
    logic               o_switch;

    int errors = 0;
    int checks = 0;
    int sw_seen = 0;

    vid_mux_sched #(
        .NIN(NIN), .LGNIN(LGNIN), .LGTIMEOUT(LGTIMEOUT), .TIMEOUT(TIMEOUT),
        .LGDWELL(LGDWELL), .DEF_SELECT(DEF_SELECT)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .i_src_valid  (valid),
        .i_out_eof    (eof),
        .i_mode       (mode),
        .i_manual_sel (msel),
        .i_dwell      (dwell),
        .o_select     (o_select),
        .o_live       (o_live),
        .o_none_live  (o_none_live),
        .o_switch     (o_switch)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: what the outputs must show after each clock edge.
    int             m_wd [NIN];
    logic [NIN-1:0] m_live = '0;
    int             m_sel = DEF_SELECT;
    bit             m_sw = 0;
    bit             m_wait = 1;
    bit             m_pend = 0;
    int             m_ptgt = 0;
    int             m_frames = 0;
    int             m_prev_mode = 0;

    function automatic int next_live(int from);
        for (int i = 1; i <= NIN; i++) begin
            int j;
            j = (from + i) % NIN;
            if (m_live[j]) return j;
        end
        return from;
    endfunction

    function automatic int lowest_live();
        for (int i = 0; i < NIN; i++)
            if (m_live[i]) return i;
        return m_sel;
    endfunction

    task automatic model_step();
        int tgt, frames_eff, frames_n, sel_n, md, ms;
        bit dead, rescan, decide, sw_n;
        if (rst) begin
            for (int k = 0; k < NIN; k++) m_wd[k] = 0;
            m_live = '0; m_sel = DEF_SELECT; m_sw = 0; m_wait = 1;
            m_pend = 0; m_frames = 0; m_prev_mode = 0;
            return;
        end
        md = (int'(mode) == 3) ? 0 : int'(mode);
        ms = int'(msel);
        frames_eff = (int'(mode) != m_prev_mode) ? 0 : m_frames;
        frames_n = frames_eff;
        sel_n = m_sel;
        sw_n = 0;
        if (m_pend) begin
            sel_n = m_ptgt; sw_n = 1; frames_n = 0; m_pend = 0;
        end else if (m_live == '0) begin
            m_wait = 1;
        end else begin
            dead   = !m_live[m_sel];
            rescan = m_wait || dead;
            decide = m_wait || dead || eof;
            tgt = m_sel;
            if (md == 0) begin
                if (ms < NIN) tgt = ms;
            end else if (md == 1) begin
                tgt = (ms < NIN && m_live[ms]) ? ms : lowest_live();
            end else begin
                if (rescan) tgt = next_live(m_sel);
                else if (eof) begin
                    if (frames_eff + 1 >= ((dwell == 0) ? 1 : int'(dwell))) begin
                        tgt = next_live(m_sel); frames_n = 0;
                    end else frames_n = frames_eff + 1;
                end
            end
            if (decide && tgt != m_sel) begin
                m_pend = 1; m_ptgt = tgt;
            end
            m_wait = 0;
        end
        m_prev_mode = int'(mode);
        for (int k = 0; k < NIN; k++) begin
            m_wd[k] = valid[k] ? TIMEOUT : ((m_wd[k] > 0) ? m_wd[k] - 1 : 0);
            m_live[k] = (m_wd[k] != 0);
        end
        m_sel = sel_n; m_sw = sw_n; m_frames = frames_n;
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        check("m_select", int'(o_select), m_sel);
        check("m_live", int'(o_live), int'(m_live));
        check("m_none_live", int'(o_none_live), int'(m_live == '0));
        check("m_switch", int'(o_switch), int'(m_sw));
    end

    always @(posedge clk) begin
        #1;
        if (o_switch) sw_seen++;
    end

    task automatic pulse_eof();
        @(negedge clk) eof = 1'b1;
        @(negedge clk) eof = 1'b0;
    endtask

    task automatic wait_sel(string name, int exp, int limit);
        int n = 0;
        while (n < limit && int'(o_select) != exp) begin
            @(posedge clk); #1; n++;
        end
        check(name, int'(o_select), exp);
    endtask

    initial begin
        int n, base;
        int cyc_exp [6];
        cyc_exp = '{0, 1, 1, 2, 2, 0};

        repeat (3) @(negedge clk);
        check("rst_select", int'(o_select), 2);
        check("rst_live", int'(o_live), 0);
        check("rst_none_live", int'(o_none_live), 1);
        check("rst_switch", int'(o_switch), 0);

        // Failover: preferred source 0 dies, fall back to 2.
        rst = 1'b0; mode = 2'd1; msel = 3'd0; valid = 5'b00101;
        wait_sel("fo_init", 0, 10);
        repeat (5) @(negedge clk);
        base = sw_seen;
        valid[0] = 1'b0;
        n = 0;
        while (n < 40 && o_live[0]) begin @(posedge clk); #1; n++; end
        check("fo_live_drop", n, 16);
        n = 0;
        while (n < 10 && int'(o_select) != 2) begin @(posedge clk); #1; n++; end
        check("fo_latency", n, 2);
        repeat (5) @(negedge clk);
        check("fo_pulses", sw_seen - base, 1);

        // Round-robin with dwell 2 over sources 0..2.
        valid = 5'b00111; mode = 2'd0; msel = 3'd0;
        repeat (3) @(negedge clk);
        pulse_eof();
        repeat (4) @(negedge clk);
        check("cyc_start", int'(o_select), 0);
        mode = 2'd2; dwell = 8'd2;
        repeat (3) @(negedge clk);
        base = sw_seen;
        for (int i = 0; i < 6; i++) begin
            pulse_eof();
            @(posedge clk); #1;
            check($sformatf("cyc_sel_%0d", i + 1), int'(o_select), cyc_exp[i]);
            repeat (3) @(negedge clk);
        end
        check("cyc_pulses", sw_seen - base, 3);

        // Manual select out of range leaves the selection alone.
        mode = 2'd0; msel = 3'd6;
        repeat (3) @(negedge clk);
        base = sw_seen;
        pulse_eof();
        repeat (4) @(negedge clk);
        check("man_oor_sel", int'(o_select), 0);
        check("man_oor_pulses", sw_seen - base, 0);

        // Dwell of zero behaves as one frame per source.
        mode = 2'd2; dwell = 8'd0;
        repeat (3) @(negedge clk);
        pulse_eof();
        @(posedge clk); #1;
        check("dwell0_sel", int'(o_select), 1);

        // Every source idles, then source 3 returns under failover.
        repeat (3) @(negedge clk);
        mode = 2'd0; msel = 3'd1; valid = '0;
        n = 0;
        while (n < 30 && !o_none_live) begin @(posedge clk); #1; n++; end
        check("idle_none_live", int'(o_none_live), 1);
        repeat (3) @(negedge clk);
        check("idle_hold", int'(o_select), 1);
        mode = 2'd1; msel = 3'd0;
        repeat (2) @(negedge clk);
        base = sw_seen;
        valid[3] = 1'b1;
        wait_sel("resume_sel", 3, 10);
        repeat (4) @(negedge clk);
        check("resume_pulses", sw_seen - base, 1);

        // Reset lands in the middle of the SWITCH cycle.
        mode = 2'd0; msel = 3'd4;
        repeat (2) @(negedge clk);
        pulse_eof();
        #2 rst = 1'b1;
        #1;
        check("rsw_select", int'(o_select), 2);
        check("rsw_live", int'(o_live), 0);
        check("rsw_none_live", int'(o_none_live), 1);
        check("rsw_switch", int'(o_switch), 0);
        @(posedge clk); #1;
        check("rsw_switch_after", int'(o_switch), 0);
        check("rsw_select_after", int'(o_select), 2);
        @(negedge clk) rst = 1'b0;
        wait_sel("post_rst_sel", 4, 10);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
